// File: rtl/rr_prio_sel.sv
// rtl/rr_prio_sel.sv - round-robin priority select: first requester at or after the pointer, cyclically
module rr_prio_sel #(
    parameter int unsigned NumIn = 32,
    parameter int unsigned IdxW  = 5
) (
    input  logic [NumIn-1:0] req,
    input  logic [IdxW-1:0]  ptr,
    output logic [IdxW-1:0]  idx,
    output logic             any
);

    logic found;

    // Two passes: the masked search covers [ptr, NumIn-1], and the unmasked
    // one provides the wrap-around to the lowest requester.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NumIn); i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                idx   = IdxW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < int'(NumIn); i++) begin
            if (!found && req[i]) begin
                idx   = IdxW'(i);
                found = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/tcdm_bank_rr_arb.sv
// rtl/tcdm_bank_rr_arb.sv - round-robin arbiter for one TCDM bank with response routing
module tcdm_bank_rr_arb #(
    parameter int unsigned NumIn         = 32,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1,
    parameter bit          WriteRespOn   = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumIn-1:0]                       req_i,
    input  logic [NumIn-1:0]                       wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]     data_i,
    output logic [NumIn-1:0]                       gnt_o,
    output logic [NumIn-1:0]                       vld_o,
    output logic [RespDataWidth-1:0]               rdata_o,
    output logic                                   req_o,
    output logic                                   wen_o,
    output logic [ReqDataWidth-1:0]                data_o,
    input  logic                                   gnt_i,
    input  logic [RespDataWidth-1:0]               rdata_i
);

    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

    if (NumIn < 1) begin : g_bad_numin
        $error("tcdm_bank_rr_arb: NumIn must be >= 1");
    end
    if (RespLat < 1) begin : g_bad_resplat
        $error("tcdm_bank_rr_arb: RespLat must be >= 1");
    end

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] winner;
    logic            any_req;
    logic            accept;

    logic [RespLat-1:0]           vld_q;
    logic [RespLat-1:0][IdxW-1:0] idx_q;

    rr_prio_sel #(
        .NumIn (NumIn),
        .IdxW  (IdxW)
    ) u_prio_sel (
        .req (req_i),
        .ptr (ptr_q),
        .idx (winner),
        .any (any_req)
    );

    assign req_o   = any_req;
    assign accept  = any_req & gnt_i;
    assign wen_o   = any_req ? wen_i[winner] : 1'b0;
    assign data_o  = any_req ? data_i[winner] : data_i[0];
    assign rdata_o = rdata_i;

    always_comb begin
        gnt_o         = '0;
        gnt_o[winner] = accept;
    end

    always_comb begin
        vld_o                     = '0;
        vld_o[idx_q[RespLat-1]]   = vld_q[RespLat-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (NumIn == 1) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (winner == IdxW'(NumIn - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Fixed-latency tracker: the bank never stalls responses, so a plain shift line suffices.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= accept & (~wen_o | WriteRespOn);
            idx_q[0] <= winner;
            for (int k = 1; k < int'(RespLat); k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_tcdm_bank_rr_arb.sv
// tb/tb_tcdm_bank_rr_arb.sv - directed table and sequence checks for tcdm_bank_rr_arb
module tb_tcdm_bank_rr_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 masters, RespLat 2, write responses enabled
    logic             rst_na;
    logic [3:0]       req_a, wen_a, gnt_oa, vld_oa;
    logic [3:0][7:0]  data_a;
    logic [15:0]      rdata_oa, rdata_a;
    logic             req_oa, wen_oa, gnt_a;
    logic [7:0]       data_oa;

    tcdm_bank_rr_arb #(
        .NumIn(4), .ReqDataWidth(8), .RespDataWidth(16), .RespLat(2), .WriteRespOn(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_na), .req_i(req_a), .wen_i(wen_a), .data_i(data_a),
        .gnt_o(gnt_oa), .vld_o(vld_oa), .rdata_o(rdata_oa), .req_o(req_oa), .wen_o(wen_oa),
        .data_o(data_oa), .gnt_i(gnt_a), .rdata_i(rdata_a)
    );

    // Instance B: 3 masters, RespLat 3, write responses suppressed
    logic             rst_nb;
    logic [2:0]       req_b, wen_b, gnt_ob, vld_ob;
    logic [2:0][7:0]  data_b;
    logic [15:0]      rdata_ob, rdata_b;
    logic             req_ob, wen_ob, gnt_b;
    logic [7:0]       data_ob;

    tcdm_bank_rr_arb #(
        .NumIn(3), .ReqDataWidth(8), .RespDataWidth(16), .RespLat(3), .WriteRespOn(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_nb), .req_i(req_b), .wen_i(wen_b), .data_i(data_b),
        .gnt_o(gnt_ob), .vld_o(vld_ob), .rdata_o(rdata_ob), .req_o(req_ob), .wen_o(wen_ob),
        .data_o(data_ob), .gnt_i(gnt_b), .rdata_i(rdata_b)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] wen;
        logic       gnt;
        logic [3:0] gnt_e;
        logic [3:0] vld_e;
        logic       req_e;
        logic       wen_e;
        logic [7:0] data_e;
        logic [1:0] ptr_e;
    } vec_t;

    vec_t vecs [21];

    task automatic drive_b(input logic [2:0] r, input logic [2:0] w, input logic g);
        @(posedge clk); #1;
        req_b = r; wen_b = w; gnt_b = g;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA0, 2'd0};
        vecs[1]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 8'hA3, 2'd0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA0, 2'd0};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'hA0, 2'd0};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'hA0, 2'd0};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'hA1, 2'd1};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0001, 1'b1, 1'b0, 8'hA2, 2'd2};
        vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b0010, 1'b1, 1'b0, 8'hA3, 2'd3};
        vecs[8]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0100, 1'b1, 1'b0, 8'hA0, 2'd0};
        vecs[9]  = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 8'hA1, 2'd1};
        vecs[10] = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 8'hA1, 2'd1};
        vecs[11] = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'hA1, 2'd1};
        vecs[12] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'hA1, 2'd1};
        vecs[13] = '{4'b0110, 4'b1001, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'hA2, 2'd2};
        vecs[14] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'hA1, 2'd3};
        vecs[15] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0100, 1'b1, 1'b1, 8'hA0, 2'd2};
        vecs[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'hA0, 2'd1};
        vecs[17] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'hA0, 2'd1};
        vecs[18] = '{4'b1110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'hA1, 2'd1};
        vecs[19] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA0, 2'd2};
        vecs[20] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'hA0, 2'd2};

        rst_na = 1'b0; rst_nb = 1'b0;
        req_a = '0; wen_a = '0; gnt_a = 1'b0; rdata_a = '0;
        req_b = '0; wen_b = '0; gnt_b = 1'b0; rdata_b = '0;
        for (int i = 0; i < 4; i++) data_a[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 3; i++) data_b[i] = 8'hB0 + 8'(i);

        repeat (2) @(negedge clk);
        chk("a_reset_ptr", 32'(dut_a.ptr_q), 32'd0);
        chk("a_reset_vld", 32'(vld_oa), 32'd0);
        chk("a_reset_gnt", 32'(gnt_oa), 32'd0);
        chk("a_reset_req", 32'(req_oa), 32'd0);
        @(posedge clk); #1;
        rst_na = 1'b1; rst_nb = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            req_a = vecs[i].req; wen_a = vecs[i].wen; gnt_a = vecs[i].gnt;
            rdata_a = 16'h1000 + 16'(i);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i),   32'(gnt_oa),   32'(vecs[i].gnt_e));
            chk($sformatf("v%0d_vld", i),   32'(vld_oa),   32'(vecs[i].vld_e));
            chk($sformatf("v%0d_req", i),   32'(req_oa),   32'(vecs[i].req_e));
            chk($sformatf("v%0d_wen", i),   32'(wen_oa),   32'(vecs[i].wen_e));
            chk($sformatf("v%0d_data", i),  32'(data_oa),  32'(vecs[i].data_e));
            chk($sformatf("v%0d_rdata", i), 32'(rdata_oa), 32'h1000 + 32'(i));
            chk($sformatf("v%0d_ptr", i),   32'(dut_a.ptr_q), 32'(vecs[i].ptr_e));
        end

        // Instance B: pointer wrap on a non-power-of-2 count and write-response suppression
        drive_b(3'b010, 3'b000, 1'b1);
        chk("b0_gnt", 32'(gnt_ob), 32'b010);
        drive_b(3'b100, 3'b000, 1'b1);
        chk("b1_ptr", 32'(dut_b.ptr_q), 32'd2);
        chk("b1_gnt", 32'(gnt_ob), 32'b100);
        drive_b(3'b110, 3'b000, 1'b1);
        chk("b2_ptr_wrap", 32'(dut_b.ptr_q), 32'd0);
        chk("b2_gnt", 32'(gnt_ob), 32'b010);
        drive_b(3'b001, 3'b001, 1'b1);
        chk("b3_ptr", 32'(dut_b.ptr_q), 32'd2);
        chk("b3_gnt", 32'(gnt_ob), 32'b001);
        chk("b3_wen", 32'(wen_ob), 32'd1);
        chk("b3_vld", 32'(vld_ob), 32'b010);
        drive_b(3'b001, 3'b000, 1'b1);
        chk("b4_vld", 32'(vld_ob), 32'b100);
        chk("b4_ptr", 32'(dut_b.ptr_q), 32'd1);
        drive_b(3'b000, 3'b000, 1'b1);
        chk("b5_vld", 32'(vld_ob), 32'b010);
        chk("b5_data_idle", 32'(data_ob), 32'hB0);
        drive_b(3'b000, 3'b000, 1'b1);
        chk("b6_vld_write_suppressed", 32'(vld_ob), 32'b000);
        drive_b(3'b000, 3'b000, 1'b1);
        chk("b7_vld_read", 32'(vld_ob), 32'b001);

        // Two reads in flight, then reset mid-operation
        drive_b(3'b001, 3'b000, 1'b1);
        chk("b8_gnt", 32'(gnt_ob), 32'b001);
        drive_b(3'b010, 3'b000, 1'b1);
        chk("b9_gnt", 32'(gnt_ob), 32'b010);
        @(posedge clk); #1;
        req_b = '0; rst_nb = 1'b0;
        #1;
        chk("b_rst_ptr", 32'(dut_b.ptr_q), 32'd0);
        chk("b_rst_vld", 32'(vld_ob), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_nb = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("b_post_rst_vld%0d", c), 32'(vld_ob), 32'd0);
        end
        chk("b_post_rst_ptr", 32'(dut_b.ptr_q), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
